// File: rtl/jtag_driver_if.sv
// Command/response channel between a scan sequencer and the JTAG driver.
// The sequencer side uses the master modport and the driver uses slave.
interface jtag_driver_if #(
  parameter int MAXLEN = 33,
  parameter int LENW   = 6
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [LENW-1:0]   cmd_len;
  logic [MAXLEN-1:0] cmd_data;
  logic              rsp_valid;
  logic [MAXLEN-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/jtag_driver.sv
// TCLK-domain TAP master: walks the TAP through IR/DR scans or a TMS reset,
// driving registered TMS/WSI and collecting WSO into the response.
module jtag_driver #(
  parameter int MAXLEN = 33,
  parameter int LENW   = 6
) (
  input  logic          TCLK,
  input  logic          TRESETN,
  jtag_driver_if.slave  bus,
  output logic          busy,
  output logic          TMS,
  output logic          WSI,
  input  logic          WSO
);

  typedef enum logic [3:0] {
    INIT, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT_ENTRY, SHIFT, UPDATE, RTI
  } state_t;

  localparam logic [LENW-1:0] MAXLEN_L = LENW'(MAXLEN);

  state_t            state, state_d;
  logic              tms_q, tms_d;
  logic              wsi_q, wsi_d;
  logic              is_ir, is_ir_d;
  logic              pend, pend_d;
  logic              rv_q, rv_d;
  logic [LENW-1:0]   len_q, len_d;
  logic [LENW-1:0]   cnt, cnt_d;
  logic [MAXLEN-1:0] sreg, sreg_d;
  logic [MAXLEN-1:0] cap, cap_d;
  logic [MAXLEN-1:0] rd_q, rd_d;
  logic [LENW-1:0]   len_eff;
  logic [LENW-1:0]   bit_idx;
  logic              ready;
  logic              accept;

  assign len_eff = (bus.cmd_len > MAXLEN_L) ? MAXLEN_L : bus.cmd_len;
  assign bit_idx = len_q - cnt;
  // Held low during the response cycle so commands are always separated by an idle cycle.
  assign ready   = (state == IDLE) && !rv_q;
  assign accept  = bus.cmd_valid && ready;

  assign bus.cmd_ready = ready;
  assign bus.rsp_valid = rv_q;
  assign bus.rsp_data  = rd_q;
  assign busy          = (state != IDLE);
  assign TMS           = tms_q;
  assign WSI           = wsi_q;

  always_ff @(posedge TCLK or negedge TRESETN) begin
    if (!TRESETN) begin
      state <= INIT;
      tms_q <= 1'b1;
      wsi_q <= 1'b0;
      is_ir <= 1'b0;
      pend  <= 1'b0;
      rv_q  <= 1'b0;
      len_q <= '0;
      cnt   <= '0;
      sreg  <= '0;
      cap   <= '0;
      rd_q  <= '0;
    end else begin
      state <= state_d;
      tms_q <= tms_d;
      wsi_q <= wsi_d;
      is_ir <= is_ir_d;
      pend  <= pend_d;
      rv_q  <= rv_d;
      len_q <= len_d;
      cnt   <= cnt_d;
      sreg  <= sreg_d;
      cap   <= cap_d;
      rd_q  <= rd_d;
    end
  end

  always_comb begin
    state_d = state;
    tms_d   = tms_q;
    wsi_d   = 1'b0;
    is_ir_d = is_ir;
    pend_d  = pend;
    rv_d    = 1'b0;
    len_d   = len_q;
    cnt_d   = cnt;
    sreg_d  = sreg;
    cap_d   = cap;
    rd_d    = rd_q;
    case (state)
      INIT: begin
        // Reset value of TMS is the first of five 1s; the fifth edge drives the single 0.
        cnt_d = cnt + LENW'(1);
        tms_d = (cnt < LENW'(4));
        if (cnt == LENW'(5)) begin
          state_d = IDLE;
          tms_d   = 1'b0;
          cnt_d   = '0;
          if (pend) begin
            rv_d   = 1'b1;
            rd_d   = cap;
            pend_d = 1'b0;
          end
        end
      end
      IDLE: begin
        tms_d = 1'b0;
        if (accept) begin
          cap_d   = '0;
          sreg_d  = bus.cmd_data;
          len_d   = len_eff;
          is_ir_d = (bus.cmd_op == 2'b01);
          case (bus.cmd_op)
            2'b10: begin
              state_d = INIT;
              tms_d   = 1'b1;
              cnt_d   = '0;
              pend_d  = 1'b1;
            end
            2'b11: begin
              rv_d = 1'b1;
              rd_d = '0;
            end
            default: begin
              if (len_eff == '0) begin
                rv_d = 1'b1;
                rd_d = '0;
              end else begin
                state_d = SEL_DR;
                tms_d   = 1'b1;
              end
            end
          endcase
        end
      end
      SEL_DR: begin
        state_d = is_ir ? SEL_IR : CAPTURE;
        tms_d   = is_ir;
      end
      SEL_IR: begin
        state_d = CAPTURE;
        tms_d   = 1'b0;
      end
      CAPTURE: begin
        state_d = SHIFT_ENTRY;
        tms_d   = 1'b0;
      end
      SHIFT_ENTRY: begin
        state_d = SHIFT;
        wsi_d   = sreg[0];
        sreg_d  = sreg >> 1;
        cnt_d   = len_q;
        tms_d   = (len_q == LENW'(1));
      end
      SHIFT: begin
        cap_d[bit_idx] = WSO;
        if (cnt == LENW'(1)) begin
          state_d = UPDATE;
          tms_d   = 1'b1;
        end else begin
          cnt_d  = cnt - LENW'(1);
          wsi_d  = sreg[0];
          sreg_d = sreg >> 1;
          tms_d  = (cnt == LENW'(2));
        end
      end
      UPDATE: begin
        state_d = RTI;
        tms_d   = 1'b0;
      end
      RTI: begin
        state_d = IDLE;
        tms_d   = 1'b0;
        rv_d    = 1'b1;
        rd_d    = cap;
      end
      default: begin
        state_d = INIT;
        tms_d   = 1'b1;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_jtag_driver.sv
// Bench for jtag_driver: behavioural TAP on the pins, a per-cycle expectation
// queue derived from the scan rules, plus directed and random commands.
module tb_jtag_driver;
  localparam int MAXLEN = 33;
  localparam int LENW   = 6;

  logic TCLK    = 1'b0;
  logic TRESETN = 1'b0;
  logic busy, TMS, WSI, WSO;

  jtag_driver_if #(.MAXLEN(MAXLEN), .LENW(LENW)) bus ();

  jtag_driver #(.MAXLEN(MAXLEN), .LENW(LENW)) dut (
    .TCLK    (TCLK),
    .TRESETN (TRESETN),
    .bus     (bus),
    .busy    (busy),
    .TMS     (TMS),
    .WSI     (WSI),
    .WSO     (WSO)
  );

  always #5 TCLK = ~TCLK;

  int n_tests = 0;
  int n_fail  = 0;
  int rsp_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural TAP: standard 16-state controller, 8-bit IR, one 33-bit TDR.
  typedef enum int {TLR, RTI, SDR, CDR, SHDR, E1DR, PDR, E2DR, UDR,
                    SIR, CIR, SHIR, E1IR, PIR, E2IR, UIR} tap_t;
  tap_t        tap = TLR;
  logic [32:0] dr_sr = '0, tdr = '0, tdr_cap = '0;
  logic [7:0]  ir_sr = '0, ir = '0;

  assign WSO = (tap == SHDR) ? dr_sr[0] : (tap == SHIR) ? ir_sr[0] : 1'b0;

  always @(posedge TCLK or negedge TRESETN) begin
    if (!TRESETN) tap <= TLR;
    else begin
      case (tap)
        CDR:  dr_sr <= tdr_cap;
        SHDR: dr_sr <= {WSI, dr_sr[32:1]};
        UDR:  tdr   <= dr_sr;
        CIR:  ir_sr <= 8'h01;
        SHIR: ir_sr <= {WSI, ir_sr[7:1]};
        UIR:  ir    <= ir_sr;
        default: ;
      endcase
      case (tap)
        TLR:  tap <= TMS ? TLR  : RTI;
        RTI:  tap <= TMS ? SDR  : RTI;
        SDR:  tap <= TMS ? SIR  : CDR;
        CDR:  tap <= TMS ? E1DR : SHDR;
        SHDR: tap <= TMS ? E1DR : SHDR;
        E1DR: tap <= TMS ? UDR  : PDR;
        PDR:  tap <= TMS ? E2DR : PDR;
        E2DR: tap <= TMS ? UDR  : SHDR;
        UDR:  tap <= TMS ? SDR  : RTI;
        SIR:  tap <= TMS ? TLR  : CIR;
        CIR:  tap <= TMS ? E1IR : SHIR;
        SHIR: tap <= TMS ? E1IR : SHIR;
        E1IR: tap <= TMS ? UIR  : PIR;
        PIR:  tap <= TMS ? E2IR : PIR;
        E2IR: tap <= TMS ? UIR  : SHIR;
        default: tap <= TMS ? SDR : RTI;
      endcase
    end
  end

  // Expected per-cycle outputs: ctl = {TMS, WSI, busy, cmd_ready, rsp_valid}.
  typedef struct {
    logic [4:0]  ctl;
    logic [32:0] rd;
  } exp_t;
  exp_t        q[$];
  logic [32:0] exp_reg = '0;

  function automatic void push(input logic [4:0] c, input logic [32:0] r);
    q.push_back('{ctl: c, rd: r});
  endfunction

  // A scan streams the TAP register's captured bits out first, then the shifted-in data.
  function automatic void scan_model(input int w, input logic [32:0] cap, input logic [32:0] data,
                                     input int l, output logic [32:0] rsp, output logic [32:0] upd);
    logic [79:0] stream, ml, mw;
    ml     = (80'd1 << l) - 80'd1;
    mw     = (80'd1 << w) - 80'd1;
    stream = (({47'd0, data} & ml) << w) | ({47'd0, cap} & mw);
    rsp    = 33'(stream & ml);
    upd    = 33'((stream >> l) & mw);
  endfunction

  function automatic int eff_len(input logic [5:0] len);
    return (len > 6'd33) ? 33 : int'(len);
  endfunction

  function automatic void plan(input logic [1:0] op, input logic [5:0] len, input logic [32:0] data);
    int l;
    logic [32:0] rsp, upd;
    l = eff_len(len);
    if (op == 2'b10) begin
      repeat (5) push(5'b10100, '0);
      push(5'b00100, '0);
      push(5'b00001, '0);
    end else if (op == 2'b11 || l == 0) begin
      push(5'b00001, '0);
    end else begin
      scan_model((op == 2'b01) ? 8 : 33, (op == 2'b01) ? 33'h01 : tdr_cap, data, l, rsp, upd);
      exp_reg = upd;
      push(5'b10100, '0);
      if (op == 2'b01) push(5'b10100, '0);
      push(5'b00100, '0);
      push(5'b00100, '0);
      for (int i = 0; i < l; i++) push({(i == l - 1), data[i], 3'b100}, '0);
      push(5'b10100, '0);
      push(5'b00100, '0);
      push(5'b00001, rsp);
    end
  endfunction

  function automatic int latency(input logic [1:0] op, input logic [5:0] len);
    int l;
    l = eff_len(len);
    if (op == 2'b10) return 7;
    if (op == 2'b11 || l == 0) return 1;
    return l + 6 + ((op == 2'b01) ? 1 : 0);
  endfunction

  initial begin : compare
    exp_t e;
    logic [32:0] hold;
    hold = '0;
    forever begin
      @(negedge TCLK);
      if (!TRESETN) begin
        q.delete();
        hold = '0;
        chk("reset_ctl", 64'({TMS, WSI, busy, bus.cmd_ready, bus.rsp_valid}), 64'(5'b10100));
        chk("reset_rsp_data", 64'(bus.rsp_data), 64'd0);
      end else begin
        if (q.size() > 0) e = q.pop_front();
        else e = '{ctl: 5'b00010, rd: '0};
        if (e.ctl[0]) hold = e.rd;
        if (bus.rsp_valid) rsp_cnt++;
        chk("ctl", 64'({TMS, WSI, busy, bus.cmd_ready, bus.rsp_valid}), 64'(e.ctl));
        chk("rsp_data", 64'(bus.rsp_data), 64'(hold));
        if (bus.cmd_valid && bus.cmd_ready) plan(bus.cmd_op, bus.cmd_len, bus.cmd_data);
      end
    end
  end

  task automatic release_reset(output int n);
    repeat (2) @(negedge TCLK);
    #1 TRESETN = 1'b1;
    repeat (4) push(5'b10100, '0);
    push(5'b00100, '0);
    n = 0;
    do begin @(negedge TCLK); n++; end while (!bus.cmd_ready && n < 50);
    @(posedge TCLK); #2;
  endtask

  task automatic send(input logic [1:0] op, input logic [5:0] len, input logic [32:0] data);
    int k;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_len   = len;
    bus.cmd_data  = data;
    k = 0;
    do begin @(negedge TCLK); k++; end while (!bus.cmd_ready && k < 300);
    if (!bus.cmd_ready) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge TCLK); #2;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n, output logic [63:0] hist);
    n = 0;
    hist = '0;
    do begin
      @(negedge TCLK);
      n++;
      if (!bus.rsp_valid) hist = {hist[62:0], TMS};
    end while (!bus.rsp_valid && n < 200);
    if (!bus.rsp_valid) chk("rsp_timeout", 64'd0, 64'd1);
    @(posedge TCLK); #2;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, rc, sel;
    logic [63:0] h, r64;
    logic [32:0] saved, data;
    logic [1:0]  op;
    logic [5:0]  len;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_len   = '0;
    bus.cmd_data  = '0;
    tdr_cap       = 33'h0CA;

    release_reset(n);
    chk("init_ready_cycles", 64'(n), 64'd6);
    chk("init_tap_rti", 64'(tap == RTI), 64'd1);

    send(2'b01, 6'd8, 33'hA5);
    wait_rsp(n, h);
    chk("ir_latency", 64'(n), 64'd15);
    chk("ir_tms_seq", h, 64'b11000000000110);
    chk("ir_rsp", 64'(bus.rsp_data), 64'h01);
    chk("ir_update", 64'(ir), 64'hA5);

    send(2'b00, 6'd33, 33'h1_5555_AAAA);
    wait_rsp(n, h);
    chk("dr33_latency", 64'(n), 64'd39);
    chk("dr33_rsp", 64'(bus.rsp_data), 64'h0CA);
    chk("dr33_update", 64'(tdr), 64'h1_5555_AAAA);

    send(2'b00, 6'd0, 33'h1_FFFF_FFFF);
    wait_rsp(n, h);
    chk("len0_latency", 64'(n), 64'd1);
    chk("len0_tap_rti", 64'(tap == RTI), 64'd1);

    send(2'b11, 6'd12, 33'h0_0000_0FFF);
    wait_rsp(n, h);
    chk("op11_latency", 64'(n), 64'd1);
    chk("op11_rsp", 64'(bus.rsp_data), 64'd0);

    send(2'b10, 6'd5, 33'h0);
    wait_rsp(n, h);
    chk("tapreset_latency", 64'(n), 64'd7);
    chk("tapreset_tms_seq", h, 64'b111110);
    chk("tapreset_tap_rti", 64'(tap == RTI), 64'd1);

    tdr_cap = 33'h1_0F0F_0F0F;
    send(2'b00, 6'd40, 33'h0_DEAD_BEEF);
    wait_rsp(n, h);
    chk("sat_latency", 64'(n), 64'd39);
    chk("sat_rsp", 64'(bus.rsp_data), 64'h1_0F0F_0F0F);
    chk("sat_update", 64'(tdr), 64'h0_DEAD_BEEF);

    tdr_cap = 33'h0_1234_5678;
    rc = rsp_cnt;
    send(2'b00, 6'd4, 33'h9);
    send(2'b00, 6'd4, 33'h6);
    wait_rsp(n, h);
    chk("b2b_rsp_pulses", 64'(rsp_cnt - rc), 64'd2);
    chk("b2b_rsp", 64'(bus.rsp_data), 64'h8);
    chk("b2b_update", 64'(tdr), 64'h0_C123_4567);

    // Reset lands in the shift cycle of bit 10 (cycle 14 after acceptance).
    saved   = tdr;
    tdr_cap = 33'h1_AAAA_0000;
    rc      = rsp_cnt;
    send(2'b00, 6'd33, 33'h0_1357_9BDF);
    repeat (13) @(posedge TCLK);
    #3 TRESETN = 1'b0;
    #1;
    chk("midrst_ctl", 64'({TMS, WSI, busy, bus.cmd_ready, bus.rsp_valid}), 64'(5'b10100));
    chk("midrst_rsp_data", 64'(bus.rsp_data), 64'd0);
    release_reset(n);
    chk("midrst_ready_cycles", 64'(n), 64'd6);
    chk("midrst_no_rsp", 64'(rsp_cnt - rc), 64'd0);
    chk("midrst_no_update", 64'(tdr), 64'(saved));
    chk("midrst_tap_rti", 64'(tap == RTI), 64'd1);

    for (int t = 0; t < 40; t++) begin
      sel = int'($urandom_range(0, 9));
      op  = (sel < 4) ? 2'b00 : (sel < 7) ? 2'b01 : (sel == 7) ? 2'b10 : (sel == 8) ? 2'b11 : 2'b00;
      len = (sel == 9) ? 6'd0 : 6'($urandom_range(0, 40));
      r64 = {$urandom, $urandom};
      data = r64[32:0];
      r64 = {$urandom, $urandom};
      tdr_cap = r64[32:0];
      repeat ($urandom_range(0, 3)) @(posedge TCLK);
      #2;
      send(op, len, data);
      wait_rsp(n, h);
      chk("rand_latency", 64'(n), 64'(latency(op, len)));
      if (op == 2'b01 && len != 6'd0) chk("rand_ir_update", 64'(ir), 64'(exp_reg[7:0]));
      if (op == 2'b00 && len != 6'd0) chk("rand_dr_update", 64'(tdr), 64'(exp_reg));
      if (op == 2'b10) chk("rand_tap_rti", 64'(tap == RTI), 64'd1);
    end

    repeat (3) @(posedge TCLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
